// File: rtl/bowling_frame_ctrl.sv
// Ten-pin bowling frame controller.
// Accepts one throw per upd strobe, tracks frame and standing pins, flags
// strikes, spares and illegal throws, and walks the three-ball tenth frame.
module bowling_frame_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       upd,
  input  logic [3:0] N,
  output logic       FT,
  output logic       NF,
  output logic       LF,
  output logic [3:0] frame,
  output logic [3:0] pins_left,
  output logic       strike,
  output logic       spare,
  output logic       err,
  output logic       done
);

  typedef enum logic [2:0] {
    OPEN1 = 3'd0,  // frames 1-9, first ball
    OPEN2 = 3'd1,  // frames 1-9, second ball
    T1    = 3'd2,  // frame 10, ball 1
    T2    = 3'd3,  // frame 10, ball 2
    T3    = 3'd4,  // frame 10, ball 3 (bonus)
    DONE  = 3'd5
  } state_t;

  state_t state;
  logic   x1;       // tenth-frame first ball was a strike
  logic   illegal;

  // A throw is rejected when the game is over or it claims more pins than stand.
  assign illegal = (state == DONE) || (N > 4'd10) || (N > pins_left);

  // Game FSM with all outputs registered; pulses default low every edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= OPEN1;
      frame     <= 4'd1;
      FT        <= 1'b1;
      NF        <= 1'b0;
      LF        <= 1'b0;
      pins_left <= 4'd10;
      strike    <= 1'b0;
      spare     <= 1'b0;
      err       <= 1'b0;
      done      <= 1'b0;
      x1        <= 1'b0;
    end else begin
      strike <= 1'b0;
      spare  <= 1'b0;
      NF     <= 1'b0;
      err    <= 1'b0;
      if (upd) begin
        if (illegal) begin
          err <= 1'b1;
        end else begin
          case (state)
            OPEN1: begin
              if (N == 4'd10) begin
                strike    <= 1'b1;
                NF        <= 1'b1;
                frame     <= frame + 4'd1;
                pins_left <= 4'd10;
                FT        <= 1'b1;
                if (frame == 4'd9) begin
                  state <= T1;
                  LF    <= 1'b1;
                end else begin
                  state <= OPEN1;
                end
              end else begin
                pins_left <= 4'd10 - N;
                FT        <= 1'b0;
                state     <= OPEN2;
              end
            end
            OPEN2: begin
              // Second ball always closes the frame; clearing the rack is a spare.
              spare     <= (N == pins_left);
              NF        <= 1'b1;
              frame     <= frame + 4'd1;
              pins_left <= 4'd10;
              FT        <= 1'b1;
              if (frame == 4'd9) begin
                state <= T1;
                LF    <= 1'b1;
              end else begin
                state <= OPEN1;
              end
            end
            T1: begin
              FT    <= 1'b0;
              state <= T2;
              if (N == 4'd10) begin
                strike    <= 1'b1;
                pins_left <= 4'd10;
                x1        <= 1'b1;
              end else begin
                pins_left <= 4'd10 - N;
                x1        <= 1'b0;
              end
            end
            T2: begin
              if (x1) begin
                // Fresh rack after a tenth-frame strike.
                state <= T3;
                if (N == 4'd10) begin
                  strike    <= 1'b1;
                  pins_left <= 4'd10;
                end else begin
                  pins_left <= 4'd10 - N;
                end
              end else if (N == pins_left) begin
                spare     <= 1'b1;
                pins_left <= 4'd10;
                state     <= T3;
              end else begin
                // Open tenth frame: no bonus ball.
                pins_left <= pins_left - N;
                state     <= DONE;
                done      <= 1'b1;
              end
            end
            T3: begin
              strike    <= (pins_left == 4'd10) && (N == 4'd10);
              spare     <= (pins_left < 4'd10) && (N == pins_left);
              pins_left <= pins_left - N;
              state     <= DONE;
              done      <= 1'b1;
            end
            default: begin
              // DONE never gets here (every throw is illegal); recover to a safe state otherwise.
              if (state != DONE) begin
                state <= OPEN1;
              end
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_bowling_frame_ctrl.sv
// Self-checking bench for bowling_frame_ctrl: stimulus pushes expected
// responses from a scoring-rules model; a monitor pops and compares each edge.
module tb_bowling_frame_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       upd;
  logic [3:0] N;
  logic       FT, NF, LF, strike, spare, err, done;
  logic [3:0] frame, pins_left;

  always #5 clk = ~clk;

  bowling_frame_ctrl dut (
    .clk(clk), .reset(reset), .upd(upd), .N(N),
    .FT(FT), .NF(NF), .LF(LF), .frame(frame), .pins_left(pins_left),
    .strike(strike), .spare(spare), .err(err), .done(done)
  );

  typedef struct packed {
    logic       err;
    logic       strike;
    logic       spare;
    logic       nf;
    logic [3:0] frame;
    logic [3:0] pins;
    logic       ft;
    logic       lf;
    logic       done;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   strikes_seen = 0;
  int   throw_no = 0;

  // Reference model: the game as a list of rolls in the current frame.
  int m_frame;
  int m_rolls[$];
  bit m_done;

  function automatic void m_reset();
    m_frame = 1;
    m_rolls.delete();
    m_done  = 1'b0;
  endfunction

  // Pins standing now; in frame 10 the rack is re-set whenever it is cleared.
  function automatic int m_standing();
    int s = 10;
    foreach (m_rolls[i]) begin
      s -= m_rolls[i];
      if (m_frame == 10 && s == 0) s = 10;
    end
    return s;
  endfunction

  function automatic exp_t m_state();
    exp_t e = '0;
    e.frame = m_frame[3:0];
    e.pins  = m_done ? 4'd0 : 4'(m_standing());
    e.ft    = !m_done && (m_rolls.size() == 0);
    e.lf    = (m_frame == 10);
    e.done  = m_done;
    return e;
  endfunction

  function automatic exp_t m_throw(input int n);
    exp_t e;
    int   s = m_standing();
    bit   st = 0, sp = 0, nf = 0, er = 0;
    if (m_done || n > s) begin
      er = 1;
    end else begin
      st = (n == 10) && (s == 10) &&
           (m_rolls.size() == 0 ||
            (m_frame == 10 && (m_rolls.size() == 2 || m_rolls[0] == 10)));
      sp = !st && (m_rolls.size() > 0) && (n == s);
      m_rolls.push_back(n);
      if (m_frame < 10) begin
        if (n == 10 || m_rolls.size() == 2) begin
          m_frame++;
          m_rolls.delete();
          nf = 1;
        end
      end else if (m_rolls.size() == 3 ||
                   (m_rolls.size() == 2 && m_rolls[0] + m_rolls[1] < 10)) begin
        m_done = 1;
      end
    end
    e = m_state();
    e.err = er; e.strike = st; e.spare = sp; e.nf = nf;
    return e;
  endfunction

  function automatic exp_t snap();
    exp_t a;
    a.err = err; a.strike = strike; a.spare = spare; a.nf = NF;
    a.frame = frame; a.pins = pins_left; a.ft = FT; a.lf = LF; a.done = done;
    return a;
  endfunction

  function automatic void compare(input string name, input exp_t a, input exp_t e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got err=%b st=%b sp=%b nf=%b fr=%0d pins=%0d ft=%b lf=%b dn=%b want err=%b st=%b sp=%b nf=%b fr=%0d pins=%0d ft=%b lf=%b dn=%b",
               name, a.err, a.strike, a.spare, a.nf, a.frame, a.pins, a.ft, a.lf, a.done,
               e.err, e.strike, e.spare, e.nf, e.frame, e.pins, e.ft, e.lf, e.done);
    end
  endfunction

  function automatic exp_t reset_vals();
    exp_t e = '0;
    e.frame = 4'd1; e.pins = 4'd10; e.ft = 1'b1;
    return e;
  endfunction

  // Monitor: every non-reset edge must match the next queued expectation.
  initial begin
    logic u_s, r_s;
    exp_t e, a;
    forever begin
      @(posedge clk);
      u_s = upd;
      r_s = reset;
      #1;
      if (!r_s) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL no_expectation got frame=%0d want queued entry", frame);
        end else begin
          e = expq.pop_front();
          a = snap();
          if (e.done) a.pins = 4'd0;
          if (u_s) begin
            throw_no++;
            $display("throw %0d N=%0d frame=%0d pins=%0d st=%b sp=%b err=%b done=%b",
                     throw_no, N, a.frame, a.pins, a.strike, a.spare, a.err, a.done);
            compare("throw", a, e);
          end else begin
            compare("idle", a, e);
          end
          if (a.strike) strikes_seen++;
        end
      end
    end
  end

  task automatic step(input bit u, input int n);
    @(negedge clk);
    upd = u;
    N   = 4'(n);
    if (u) expq.push_back(m_throw(n));
    else   expq.push_back(m_state());
  endtask

  task automatic new_game();
    @(negedge clk);
    upd = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    expq.push_back(m_state());
  endtask

  task automatic throws(input int n, input int cnt);
    for (int i = 0; i < cnt; i++) step(1'b1, n);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1; upd = 1'b0; N = 4'd0;
    m_reset();
    #12;
    compare("reset_state", snap(), reset_vals());
    @(negedge clk);
    reset = 1'b0;
    expq.push_back(m_state());

    // Perfect game, then one extra throw.
    strikes_seen = 0;
    throws(10, 12);
    settle();
    checks++;
    if (strikes_seen != 12) begin
      errors++;
      $display("FAIL perfect_strikes got %0d want 12", strikes_seen);
    end
    step(1'b1, 10);

    // Gutter game plus a 21st throw.
    new_game();
    throws(0, 21);

    // Tenth-frame spare with bonus ball.
    new_game();
    throws(0, 18);
    step(1'b1, 4); step(1'b1, 6); step(1'b1, 5);

    // Illegal pin counts.
    new_game();
    step(1'b1, 7); step(1'b1, 5); step(1'b1, 3);
    new_game();
    step(1'b1, 11); step(1'b0, 0); step(1'b1, 15);

    // Tenth frame strike then open rack.
    new_game();
    for (int f = 0; f < 9; f++) begin step(1'b1, 3); step(1'b1, 4); end
    step(1'b1, 10); step(1'b1, 3); step(1'b1, 8); step(1'b1, 7);

    // Reset mid-game in frame 5, second ball, with upd held high.
    new_game();
    for (int f = 0; f < 4; f++) begin step(1'b1, 3); step(1'b1, 4); end
    step(1'b1, 2);
    @(negedge clk);
    upd = 1'b1; N = 4'd5;
    #1 reset = 1'b1;
    #1 compare("async_reset", snap(), reset_vals());
    @(posedge clk);
    #1 compare("upd_during_reset", snap(), reset_vals());
    @(negedge clk);
    reset = 1'b0; upd = 1'b0;
    m_reset();
    expq.push_back(m_state());

    // Randomised games, including illegal throws and idle gaps.
    for (int g = 0; g < 25; g++) begin
      int extra = 0;
      int guard = 0;
      new_game();
      while (extra < 2 && guard < 60) begin
        int s = m_standing();
        int r = $urandom_range(0, 9);
        int n;
        guard++;
        if (m_done) extra++;
        if (r == 0)      n = $urandom_range(11, 15);
        else if (r == 1) n = (s < 15) ? s + 1 : 15;
        else if (r <= 3) n = s;
        else             n = $urandom_range(0, s);
        if ($urandom_range(0, 4) == 0) step(1'b0, n);
        step(1'b1, n);
      end
    end

    settle();
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d entries want 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
